// File: rtl/spi_master_multi.sv
// SPI master: one full-duplex word per accepted start, all four CPOL/CPHA modes,
// runtime SCLK divider and one-hot active-low slave selects.
// Optional feature: define SPI_LSB_FIRST_EN to add the lsb_first input.
module spi_master_multi #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_SS = 4,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [DATA_W-1:0]                             data_in,
  input  logic                                          cpol,
  input  logic                                          cpha,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
  input  logic [DIV_W-1:0]                              clk_div,
`ifdef SPI_LSB_FIRST_EN
  input  logic                                          lsb_first,
`endif
  output logic [DATA_W-1:0]                             data_out,
  output logic                                          done,
  output logic                                          busy,
  output logic                                          sclk,
  output logic                                          mosi,
  input  logic                                          miso,
  output logic [NUM_SS-1:0]                             ss_n
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LastEdge = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d, edge_next;
  logic                cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
  logic [DATA_W-1:0]   load, rx_shift;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
  logic                tick, leading;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction
`endif

  // Half-period elapsed; the next edge index is odd for leading edges.
  assign tick      = (cnt_q == div_q);
  assign edge_next = edge_q + 1'b1;
  assign leading   = edge_next[0];

  // Next-state, shift-register and output-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    load       = data_in;
    rx_shift   = {rx_q[DATA_W-2:0], miso};
`ifdef SPI_LSB_FIRST_EN
    lsb_d = lsb_q;
    if (lsb_first) load = bit_rev(data_in);
    // LSB arrives first, so shift toward bit 0 to keep data_out in natural order.
    if (lsb_q) rx_shift = {miso, rx_q[DATA_W-1:1]};
`endif
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        ss_n_d = '1;
        mosi_d = 1'b0;
        cnt_d  = '0;
        edge_d = '0;
        if (start) begin
          busy_d  = 1'b1;
          // Out-of-range index shifts the one-hot out entirely: no select asserts.
          ss_n_d  = ~(NUM_SS'(1) << ss_sel);
          div_d   = clk_div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          rx_d    = '0;
`ifdef SPI_LSB_FIRST_EN
          lsb_d   = lsb_first;
`endif
          if (!cpha) begin
            mosi_d = load[DATA_W-1];
            tx_d   = {load[DATA_W-2:0], 1'b0};
          end else begin
            tx_d   = load;
          end
          state_d = StLead;
        end
      end
      StLead, StXfer: begin
        if (tick) begin
          cnt_d  = '0;
          edge_d = edge_next;
          sclk_d = ~sclk_q;
          if (leading ^ cpha_q) begin
            rx_d = rx_shift;
          end else if (edge_next != LastEdge) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          state_d = (edge_next == LastEdge) ? StTrail : StXfer;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTrail: begin
        sclk_d = cpol_q;
        if (tick) begin
          cnt_d      = '0;
          ss_n_d     = '1;
          mosi_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = rx_q;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_q     <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q      <= lsb_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi. NUM_SS=5 gives a 3-bit ss_sel so that an
// out-of-range index (7) is reachable for the dummy-clocking case.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       miso = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] ss_sel = 3'd0;
  logic [7:0] clk_div = 8'h00;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first = 1'b0;
`endif
  logic [7:0] data_out;
  logic       done, busy, sclk, mosi;
  logic [4:0] ss_n;

  spi_master_multi #(.DATA_W(8), .NUM_SS(5), .DIV_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .cpol     (cpol),
    .cpha     (cpha),
    .ss_sel   (ss_sel),
    .clk_div  (clk_div),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .data_out (data_out),
    .done     (done),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .ss_n     (ss_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] slave;   // word the slave model shifts out
    logic [7:0] dout;    // expected data_out at done
    logic [7:0] mosi_w;  // expected serial mosi word, first bit in bit 7
    logic [4:0] ssn;     // expected ss_n while selected
    int         cycles;  // expected done cycle, accept cycle = 0
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;
  bit   active = 0;
  int   cyc, k;
  logic prev_sclk;
  logic [7:0] cap;
  bit   ss_bad, sclk_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic slave_bit(input exp_t e, input int kk);
    int j;
    if (e.cpha) j = (kk == 0) ? 0 : (kk + 1) / 2 - 1;
    else j = kk / 2;
    if (j > 7) return 1'b0;
    return e.lsb ? e.slave[j] : e.slave[7-j];
  endfunction

  // Monitor + SPI slave model, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (active) begin
        void'(sb.pop_front());
        active = 0;
      end
    end else begin
      if (active) begin
        cyc++;
        if (sclk !== prev_sclk) begin
          k++;
          if (k[0] != cur.cpha) cap = {cap[6:0], mosi};
        end
        prev_sclk = sclk;
        if (cyc == 1 && sclk !== cur.cpol) sclk_bad = 1;
        if (!done && ss_n !== cur.ssn) ss_bad = 1;
        miso = slave_bit(cur, k);
      end
      if (done) begin
        n_done++;
        if (!active || sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL spurious_done: got done=1 required no transfer in flight");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.dout));
          chk("mosi_word", 32'(cap), 32'(e.mosi_w));
          chk("sclk_edges", 32'(k), 32'd16);
          chk("done_cycle", 32'(cyc), 32'(e.cycles));
          chk("ss_n_during", 32'(ss_bad), 32'd0);
          chk("sclk_idle_lvl", 32'(sclk_bad), 32'd0);
          chk("ss_n_at_done", 32'(ss_n), 32'h1f);
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("mosi_at_done", 32'(mosi), 32'd0);
          chk("sclk_rest", 32'(sclk), 32'(e.cpol));
        end
        active = 0;
      end
      if (start && !busy) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL accept_no_exp: got accept required none");
        end else begin
          cur = sb[0];
          active = 1;
          cyc = 0;
          k = 0;
          cap = 8'h00;
          ss_bad = 0;
          sclk_bad = 0;
          prev_sclk = cur.cpol;
          miso = slave_bit(cur, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input exp_t e, input logic [7:0] din, input logic [2:0] sel,
                       input logic [7:0] div);
    sb.push_back(e);
    data_in = din;
    cpol    = e.cpol;
    cpha    = e.cpha;
    ss_sel  = sel;
    clk_div = div;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = e.lsb;
`endif
    start = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sb.size() == 0 && !busy) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL %s_timeout: got busy=%0b pending=%0d required idle", nm, busy, sb.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   hit;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'h1f);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Mode 0, div 0: A5 out, 3C in, slave 2, done at 1+17*1.
    e = '{cpol:0, cpha:0, lsb:0, slave:8'h3C, dout:8'h3C, mosi_w:8'hA5, ssn:5'b11011, cycles:18};
    issue(e, 8'hA5, 3'd2, 8'd0);
    tick();
    start = 1'b0;
    wait_idle("mode0");

    // Mode 3, div 3: SCLK idles high first; done at 1+17*4.
    cpol = 1'b1;
    repeat (2) tick();
    chk("idle_sclk_cpol1", 32'(sclk), 32'd1);
    e = '{cpol:1, cpha:1, lsb:0, slave:8'h81, dout:8'h81, mosi_w:8'hFF, ssn:5'b11110, cycles:69};
    issue(e, 8'hFF, 3'd0, 8'd3);
    tick();
    start = 1'b0;
    repeat (4) tick();
    // Request while busy, with different settings: must be ignored.
    data_in = 8'h00;
    cpol = 1'b0;
    clk_div = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("mode3");
    chk("dout_hold", 32'(data_out), 32'h81);

    // Back-to-back: mode 1 then mode 2 with start held high.
    e = '{cpol:0, cpha:1, lsb:0, slave:8'hC3, dout:8'hC3, mosi_w:8'h5A, ssn:5'b11110, cycles:35};
    issue(e, 8'h5A, 3'd0, 8'd1);
    tick();
    e = '{cpol:1, cpha:0, lsb:0, slave:8'h69, dout:8'h69, mosi_w:8'h96, ssn:5'b01111, cycles:35};
    issue(e, 8'h96, 3'd4, 8'd1);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin
        hit = 1;
        break;
      end
    end
    chk("b2b_first_done", 32'(hit), 32'd1);
    tick();
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    wait_idle("b2b");

    // Reset at SCLK edge 7 of a transfer; this entry is discarded.
    e = '{cpol:0, cpha:0, lsb:0, slave:8'hFF, dout:8'hFF, mosi_w:8'hC3, ssn:5'b10111, cycles:52};
    issue(e, 8'hC3, 3'd3, 8'd2);
    tick();
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (active && k == 7) begin
        hit = 1;
        break;
      end
    end
    chk("edge7_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(ss_n), 32'h1f);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", 32'(data_out), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Transfer after reset, mode 0.
    e = '{cpol:0, cpha:0, lsb:0, slave:8'hA5, dout:8'hA5, mosi_w:8'h3C, ssn:5'b11101, cycles:18};
    issue(e, 8'h3C, 3'd1, 8'd0);
    tick();
    start = 1'b0;
    wait_idle("post_rst");

    // Out-of-range select: dummy clocking, no ss_n asserts.
`ifdef SPI_LSB_FIRST_EN
    e = '{cpol:0, cpha:0, lsb:1, slave:8'h55, dout:8'h55, mosi_w:8'h80, ssn:5'b11111, cycles:18};
`else
    e = '{cpol:0, cpha:0, lsb:0, slave:8'h55, dout:8'h55, mosi_w:8'h01, ssn:5'b11111, cycles:18};
`endif
    issue(e, 8'h01, 3'd7, 8'd0);
    tick();
    start = 1'b0;
    wait_idle("dummy");

    chk("done_count", 32'(n_done), 32'd6);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
